sseg_of_poller: RTL and testbench

//  Avalon-MM initiator for the seven-segment counter-overflow PIO slave (1-bit input, edge capture at

---
 rtl/sseg_of_poller.sv | 128 ++++++++++++
 tb/tb_sseg_of_poller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_of_poller.sv
// Avalon-MM poller for the seven-segment counter-overflow PIO: reads edge capture, clears on hit, reads level.
// Define SSEG_OF_POLL_IRQ_EN to add the sticky irq output and its irq_ack input.
module sseg_of_poller #(
    parameter int POLL_DIV = 1000,
    parameter int DIV_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear_count,
    output logic [1:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    output logic             of_pulse,
    output logic [CNT_W-1:0] of_count,
    output logic             count_wrap,
    output logic             level,
    output logic             busy
`ifdef SSEG_OF_POLL_IRQ_EN
    ,
    output logic             irq,
    input  logic             irq_ack
`endif
);

    // state   | meaning
    // IDLE    | interval counting between polls
    // RDCAP_A | capture register address presented
    // RDCAP_S | capture readdata sampled
    // CLR     | one-cycle write to clear the capture
    // RDLVL_A | level register address presented
    // RDLVL_S | level readdata sampled
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RDCAP_A = 3'd1;
    localparam logic [2:0] RDCAP_S = 3'd2;
    localparam logic [2:0] CLR     = 3'd3;
    localparam logic [2:0] RDLVL_A = 3'd4;
    localparam logic [2:0] RDLVL_S = 3'd5;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             cnt_inc;
    logic             unused_rd;

    assign avm_writedata = 32'h0;
    assign unused_rd     = ^avm_readdata[31:1];
    assign cnt_inc       = (state == CLR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && div_cnt == DIV_LAST) state_nxt = RDCAP_A;
            RDCAP_A: state_nxt = RDCAP_S;
            RDCAP_S: state_nxt = avm_readdata[0] ? CLR : RDLVL_A;
            CLR:     state_nxt = RDLVL_A;
            RDLVL_A: state_nxt = RDLVL_S;
            RDLVL_S: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (state != IDLE || !enable || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Bus outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            avm_address    <= 2'd0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            of_pulse       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            avm_address    <= (state_nxt == RDCAP_A || state_nxt == RDCAP_S || state_nxt == CLR)
                              ? 2'd3 : 2'd0;
            avm_chipselect <= (state_nxt != IDLE);
            avm_write_n    <= (state_nxt != CLR);
            of_pulse       <= (state_nxt == CLR);
            busy           <= (state_nxt != IDLE);
        end
    end

    // The count moves on the edge that ends CLR, so a clear during CLR leaves exactly that event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            of_count   <= '0;
            count_wrap <= 1'b0;
            level      <= 1'b0;
        end else begin
            if (clear_count) begin
                of_count   <= cnt_inc ? CNT_W'(1) : '0;
                count_wrap <= 1'b0;
            end else if (cnt_inc) begin
                of_count <= of_count + CNT_W'(1);
                if (&of_count) count_wrap <= 1'b1;
            end
            if (state == RDLVL_S) level <= avm_readdata[0];
        end
    end

`ifdef SSEG_OF_POLL_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (of_pulse) begin
            irq <= 1'b1;
        end else if (irq_ack) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sseg_of_poller.sv
// Directed bench for sseg_of_poller with a registered-readdata edge-capture PIO slave model.
// Build with SSEG_OF_POLL_IRQ_EN defined to also exercise the irq/irq_ack ports.
module tb_sseg_of_poller;

    logic        clk;
    logic        reset_n;
    logic        slv_rst_n;
    logic        enable;
    logic        clear_count;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        of_pulse;
    logic [3:0]  of_count;
    logic        count_wrap;
    logic        level;
    logic        busy;
    logic        of_in;
`ifdef SSEG_OF_POLL_IRQ_EN
    logic        irq;
    logic        irq_ack;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;

    logic slv_cap;
    logic slv_prev;

    sseg_of_poller #(.POLL_DIV(4), .DIV_W(16), .CNT_W(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .clear_count    (clear_count),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .of_pulse       (of_pulse),
        .of_count       (of_count),
        .count_wrap     (count_wrap),
        .level          (level),
        .busy           (busy)
`ifdef SSEG_OF_POLL_IRQ_EN
        ,
        .irq            (irq),
        .irq_ack        (irq_ack)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PIO slave: rising edges set the capture, any write to offset 3 clears it, readdata registered.
    always @(posedge clk or negedge slv_rst_n) begin
        if (!slv_rst_n) begin
            slv_cap      <= 1'b0;
            slv_prev     <= 1'b0;
            avm_readdata <= 32'h0;
        end else begin
            slv_prev <= of_in;
            if (avm_chipselect && !avm_write_n && avm_address == 2'd3) slv_cap <= 1'b0;
            else if (of_in && !slv_prev) slv_cap <= 1'b1;
            if (avm_chipselect && avm_write_n)
                avm_readdata <= {31'h5A5A5A5A, (avm_address == 2'd0) ? of_in : slv_cap};
            else
                avm_readdata <= 32'h0;
        end
    end

    always @(posedge clk) begin
        if (avm_chipselect && !avm_write_n) wr_cnt <= wr_cnt + 1;
    end

    task automatic edge_in();
        of_in = 1'b1;
        @(negedge clk);
        of_in = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a poll sequence and measures it; len = -1 when no sequence starts in time.
    task automatic run_seq(output int len, output int wr, output int pl, output logic [1:0] wa);
        int t;
        len = -1; wr = 0; pl = 0; wa = 2'd0; t = 0;
        while (!busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!busy) return;
        len = 0;
        while (busy && len < 20) begin
            len++;
            if (!avm_write_n) begin
                wr++;
                wa = avm_address;
            end
            if (of_pulse) pl++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; slv_rst_n = 1'b0; enable = 1'b0; clear_count = 1'b0; of_in = 1'b0;
`ifdef SSEG_OF_POLL_IRQ_EN
        irq_ack = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1; slv_rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (avm_address !== 2'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", avm_address); end
        n_checks++; if (avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL rst_cs got %b want 0", avm_chipselect); end
        n_checks++; if (avm_write_n !== 1'b1) begin n_fail++; $display("FAIL rst_write_n got %b want 1", avm_write_n); end
        n_checks++; if (avm_writedata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", avm_writedata); end
        n_checks++; if (of_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse got %b want 0", of_pulse); end
        n_checks++; if (of_count !== 4'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", of_count); end
        n_checks++; if (count_wrap !== 1'b0) begin n_fail++; $display("FAIL rst_wrap got %b want 0", count_wrap); end
        n_checks++; if (level !== 1'b0) begin n_fail++; $display("FAIL rst_level got %b want 0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
`ifdef SSEG_OF_POLL_IRQ_EN
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq); end
`endif
    endtask

    task automatic test_single_event();
        int len, wr, pl, gap;
        logic [1:0] wa;
        edge_in();
        enable = 1'b1;
        run_seq(len, wr, pl, wa);
        n_checks++; if (len !== 5) begin n_fail++; $display("FAIL hit_len got %0d want 5", len); end
        n_checks++; if (wr !== 1) begin n_fail++; $display("FAIL hit_writes got %0d want 1", wr); end
        n_checks++; if (wa !== 2'd3) begin n_fail++; $display("FAIL hit_waddr got %0d want 3", wa); end
        n_checks++; if (pl !== 1) begin n_fail++; $display("FAIL hit_pulses got %0d want 1", pl); end
        n_checks++; if (of_count !== 4'd1) begin n_fail++; $display("FAIL hit_count got %0d want 1", of_count); end
        n_checks++; if (level !== 1'b0) begin n_fail++; $display("FAIL hit_level got %b want 0", level); end
        gap = 0;
        while (!busy && gap < 60) begin
            gap++;
            @(negedge clk);
        end
        n_checks++; if (gap !== 4) begin n_fail++; $display("FAIL idle_gap got %0d want 4", gap); end
        run_seq(len, wr, pl, wa);
        n_checks++; if (len !== 4) begin n_fail++; $display("FAIL miss_len got %0d want 4", len); end
        n_checks++; if (wr !== 0) begin n_fail++; $display("FAIL miss_writes got %0d want 0", wr); end
        n_checks++; if (of_count !== 4'd1) begin n_fail++; $display("FAIL miss_count got %0d want 1", of_count); end
    endtask

    task automatic test_level_held();
        int len, wr, pl;
        logic [1:0] wa;
        of_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_seq(len, wr, pl, wa);
            n_checks++; if (len !== ((i == 0) ? 5 : 4)) begin n_fail++; $display("FAIL held_len[%0d] got %0d", i, len); end
            n_checks++; if (level !== 1'b1) begin n_fail++; $display("FAIL held_level[%0d] got %b want 1", i, level); end
            n_checks++; if (of_count !== 4'd2) begin n_fail++; $display("FAIL held_count[%0d] got %0d want 2", i, of_count); end
        end
        of_in = 1'b0;
    endtask

    task automatic test_wrap();
        int len, wr, pl;
        logic [1:0] wa;
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        n_checks++; if (of_count !== 4'd0) begin n_fail++; $display("FAIL clr_count got %0d want 0", of_count); end
        n_checks++; if (count_wrap !== 1'b0) begin n_fail++; $display("FAIL clr_wrap got %b want 0", count_wrap); end
        for (int i = 1; i <= 16; i++) begin
            edge_in();
            run_seq(len, wr, pl, wa);
            n_checks++; if (len !== 5) begin n_fail++; $display("FAIL wrap_len[%0d] got %0d want 5", i, len); end
            if (i == 15) begin
                n_checks++; if (of_count !== 4'd15) begin n_fail++; $display("FAIL wrap_c15 got %0d want 15", of_count); end
                n_checks++; if (count_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_w15 got %b want 0", count_wrap); end
            end
        end
        n_checks++; if (of_count !== 4'd0) begin n_fail++; $display("FAIL wrap_c16 got %0d want 0", of_count); end
        n_checks++; if (count_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_w16 got %b want 1", count_wrap); end
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        n_checks++; if (count_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_clr got %b want 0", count_wrap); end
    endtask

    task automatic test_clear_coincident();
        int t;
        edge_in();
        t = 0;
        while (!of_pulse && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_checks++; if (of_pulse !== 1'b1) begin n_fail++; $display("FAIL coin_timeout got %b want 1", of_pulse); end
        clear_count = 1'b1;
        @(negedge clk);
        clear_count = 1'b0;
        n_checks++; if (of_count !== 4'd1) begin n_fail++; $display("FAIL coin_count got %0d want 1", of_count); end
        n_checks++; if (count_wrap !== 1'b0) begin n_fail++; $display("FAIL coin_wrap got %b want 0", count_wrap); end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_enable_drop();
        int t, len, seen;
        edge_in();
        t = 0;
        while (!busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        enable = 1'b0;
        len = 0;
        while (busy && len < 20) begin
            len++;
            @(negedge clk);
        end
        n_checks++; if (len !== 5) begin n_fail++; $display("FAIL drop_len got %0d want 5", len); end
        n_checks++; if (of_count !== 4'd2) begin n_fail++; $display("FAIL drop_count got %0d want 2", of_count); end
        seen = 0;
        repeat (20) begin
            if (busy) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL drop_idle busy cycles %0d want 0", seen); end
        enable = 1'b1;
    endtask

`ifdef SSEG_OF_POLL_IRQ_EN
    task automatic test_irq();
        int t;
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack0 got %b want 0", irq); end
        for (int k = 0; k < 2; k++) begin
            edge_in();
            t = 0;
            while (!of_pulse && t < 60) begin
                @(negedge clk);
                t++;
            end
            if (k == 1) irq_ack = 1'b1;
            @(negedge clk);
            irq_ack = 1'b0;
            n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set[%0d] got %b want 1", k, irq); end
            repeat (3) @(negedge clk);
            n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold[%0d] got %b want 1", k, irq); end
            irq_ack = 1'b1;
            @(negedge clk);
            irq_ack = 1'b0;
            n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr[%0d] got %b want 0", k, irq); end
        end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask
`endif

    task automatic test_reset_mid_clr();
        int t, wr0, seen;
        edge_in();
        t = 0;
        while (!of_pulse && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_checks++; if (avm_write_n !== 1'b0) begin n_fail++; $display("FAIL mid_inclr write_n got %b want 0", avm_write_n); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (avm_write_n !== 1'b1) begin n_fail++; $display("FAIL mid_write_n got %b want 1", avm_write_n); end
        n_checks++; if (avm_chipselect !== 1'b0) begin n_fail++; $display("FAIL mid_cs got %b want 0", avm_chipselect); end
        n_checks++; if (avm_address !== 2'd0) begin n_fail++; $display("FAIL mid_addr got %0d want 0", avm_address); end
        n_checks++; if (of_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_pulse got %b want 0", of_pulse); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_checks++; if (of_count !== 4'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", of_count); end
        n_checks++; if (level !== 1'b0) begin n_fail++; $display("FAIL mid_level got %b want 0", level); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr0 = wr_cnt;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!avm_write_n || busy) seen++;
        end
        n_checks++; if (wr_cnt - wr0 !== 0) begin n_fail++; $display("FAIL mid_nowrite got %0d writes want 0", wr_cnt - wr0); end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_quiet got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_level_held();
        test_wrap();
        test_clear_coincident();
        test_enable_drop();
`ifdef SSEG_OF_POLL_IRQ_EN
        test_irq();
`endif
        test_reset_mid_clr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
